// File: rtl/hamming_pkg.sv
// Shared constants and helpers for the extended Hamming(8,4) SECDED codec.
// Code layout: bit 0 is overall parity, bits 7:1 are Hamming positions 1..7.
package hamming_pkg;

  localparam int unsigned CODE_W = 8;
  localparam int unsigned DATA_W = 4;
  localparam int unsigned SYND_W = 3;

  localparam int unsigned POS_P1 = 1;
  localparam int unsigned POS_P2 = 2;
  localparam int unsigned POS_D0 = 3;
  localparam int unsigned POS_P4 = 4;
  localparam int unsigned POS_D1 = 5;
  localparam int unsigned POS_D2 = 6;
  localparam int unsigned POS_D3 = 7;

  localparam logic [1:0] STAT_OK     = 2'b00;
  localparam logic [1:0] STAT_CORR   = 2'b01;
  localparam logic [1:0] STAT_UNCORR = 2'b10;

  function automatic logic [DATA_W-1:0] extract_data(input logic [CODE_W-1:0] code);
    return {code[POS_D3], code[POS_D2], code[POS_D1], code[POS_D0]};
  endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome and overall-parity computation for one 8-bit codeword.
module hamming_syndrome
  import hamming_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [SYND_W-1:0] synd,
  output logic              par
);

  assign synd[0] = code[POS_P1] ^ code[POS_D0] ^ code[POS_D1] ^ code[POS_D3];
  assign synd[1] = code[POS_P2] ^ code[POS_D0] ^ code[POS_D2] ^ code[POS_D3];
  assign synd[2] = code[POS_P4] ^ code[POS_D1] ^ code[POS_D2] ^ code[POS_D3];
  assign par     = ^code;

endmodule

// File: rtl/hamming_secded_decoder.sv
// Two-stage SECDED decoder with valid/ready handshake and saturating error counters.
// Stage 1 captures the code and syndrome; stage 2 holds the corrected result.
module hamming_secded_decoder
  import hamming_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_stat,
  output logic [SYND_W-1:0] out_synd,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt
);

  logic              adv;
  logic [SYND_W-1:0] in_synd;
  logic              in_par;

  logic              s1_valid_q;
  logic [CODE_W-1:0] s1_code_q;
  logic [SYND_W-1:0] s1_synd_q;
  logic              s1_par_q;

  logic [CODE_W-1:0] flip;
  logic [DATA_W-1:0] data_d;
  logic [1:0]        stat_d;
  logic              out_hs;

  // Both stages move together; a stalled output freezes the whole pipe.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign out_hs   = out_valid && out_ready;

  hamming_syndrome u_syndrome (
    .code (in_code),
    .synd (in_synd),
    .par  (in_par)
  );

  always_comb begin
    flip   = '0;
    stat_d = STAT_OK;
    if (s1_synd_q != '0 && s1_par_q) begin
      flip[s1_synd_q] = 1'b1;
      stat_d          = STAT_CORR;
    end else if (s1_synd_q == '0 && s1_par_q) begin
      stat_d = STAT_CORR;
    end else if (s1_synd_q != '0 && !s1_par_q) begin
      stat_d = STAT_UNCORR;
    end
    data_d = extract_data(s1_code_q ^ flip);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_code_q  <= '0;
      s1_synd_q  <= '0;
      s1_par_q   <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_stat   <= STAT_OK;
      out_synd   <= '0;
    end else if (adv) begin
      s1_valid_q <= in_valid && in_ready;
      out_valid  <= s1_valid_q;
      if (in_valid) begin
        s1_code_q <= in_code;
        s1_synd_q <= in_synd;
        s1_par_q  <= in_par;
      end
      if (s1_valid_q) begin
        out_data <= data_d;
        out_stat <= stat_d;
        out_synd <= s1_synd_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (out_hs) begin
      if (out_stat == STAT_CORR && corr_cnt != '1) begin
        corr_cnt <= corr_cnt + CNT_W'(1);
      end
      if (out_stat == STAT_UNCORR && uncorr_cnt != '1) begin
        uncorr_cnt <= uncorr_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Directed bench for hamming_secded_decoder with narrow counters to reach saturation.
module tb_hamming_secded_decoder;

  localparam int unsigned CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_code;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       out_data;
  logic [1:0]       out_stat;
  logic [2:0]       out_synd;
  logic             cnt_clr;
  logic [CNT_W-1:0] corr_cnt;
  logic [CNT_W-1:0] uncorr_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hamming_secded_decoder #(
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_code    (in_code),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_stat   (out_stat),
    .out_synd   (out_synd),
    .cnt_clr    (cnt_clr),
    .corr_cnt   (corr_cnt),
    .uncorr_cnt (uncorr_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_word(input string tag, input logic [7:0] code, input logic [3:0] d,
                          input logic [1:0] st, input logic [2:0] sy);
    in_code   = code;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check_eq({tag, "_lat"}, 32'(out_valid), 32'd0);
    step();
    check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
    check_eq({tag, "_data"}, 32'(out_data), 32'(d));
    check_eq({tag, "_stat"}, 32'(out_stat), 32'(st));
    check_eq({tag, "_synd"}, 32'(out_synd), 32'(sy));
    step();
    check_eq({tag, "_drain"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_code   = 8'h00;
    out_ready = 1'b1;
    cnt_clr   = 1'b0;
    step();
    step();
    rst = 1'b0;
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_data", 32'(out_data), 32'd0);
    check_eq("rst_stat", 32'(out_stat), 32'd0);
    check_eq("rst_synd", 32'(out_synd), 32'd0);
    check_eq("rst_corr", 32'(corr_cnt), 32'd0);
    check_eq("rst_uncorr", 32'(uncorr_cnt), 32'd0);
    check_eq("rst_ready", 32'(in_ready), 32'd1);

    run_word("clean", 8'hAA, 4'hB, 2'b00, 3'd0);
    check_eq("clean_corr", 32'(corr_cnt), 32'd0);
    check_eq("clean_uncorr", 32'(uncorr_cnt), 32'd0);

    run_word("single", 8'h8A, 4'hB, 2'b01, 3'd5);
    check_eq("single_corr", 32'(corr_cnt), 32'd1);

    run_word("parity", 8'hAB, 4'hB, 2'b01, 3'd0);
    check_eq("parity_corr", 32'(corr_cnt), 32'd2);

    run_word("double", 8'hAC, 4'hB, 2'b10, 3'd3);
    check_eq("double_uncorr", 32'(uncorr_cnt), 32'd1);
    check_eq("double_corr", 32'(corr_cnt), 32'd2);

    // Backpressure: AA, 8A, AC with the consumer stalled.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_code   = 8'hAA;
    step();
    check_eq("bp_ready0", 32'(in_ready), 32'd1);
    in_code = 8'h8A;
    step();
    check_eq("bp_valid", 32'(out_valid), 32'd1);
    check_eq("bp_ready_low", 32'(in_ready), 32'd0);
    in_code = 8'hAC;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("bp_hold_valid", 32'(out_valid), 32'd1);
      check_eq("bp_hold_data", 32'(out_data), 32'hB);
      check_eq("bp_hold_stat", 32'(out_stat), 32'd0);
      check_eq("bp_hold_ready", 32'(in_ready), 32'd0);
    end
    check_eq("bp_hold_corr", 32'(corr_cnt), 32'd2);
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check_eq("bp_w2_valid", 32'(out_valid), 32'd1);
    check_eq("bp_w2_stat", 32'(out_stat), 32'd1);
    check_eq("bp_w2_synd", 32'(out_synd), 32'd5);
    step();
    check_eq("bp_w3_valid", 32'(out_valid), 32'd1);
    check_eq("bp_w3_stat", 32'(out_stat), 32'd2);
    check_eq("bp_w3_synd", 32'(out_synd), 32'd3);
    step();
    check_eq("bp_done_valid", 32'(out_valid), 32'd0);
    check_eq("bp_corr", 32'(corr_cnt), 32'd3);
    check_eq("bp_uncorr", 32'(uncorr_cnt), 32'd2);

    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    check_eq("clr_corr", 32'(corr_cnt), 32'd0);
    check_eq("clr_uncorr", 32'(uncorr_cnt), 32'd0);

    // Five back-to-back corrected words saturate a 2-bit counter at 3.
    in_valid = 1'b1;
    in_code  = 8'h8A;
    for (int i = 0; i < 5; i++) begin
      step();
      if (i >= 1) check_eq("stream_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    step();
    check_eq("stream_last", 32'(out_valid), 32'd1);
    step();
    check_eq("stream_end", 32'(out_valid), 32'd0);
    check_eq("sat_corr", 32'(corr_cnt), 32'd3);

    // Clear wins over a same-cycle counting handshake.
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    run_word("pre_clr", 8'h8A, 4'hB, 2'b01, 3'd5);
    check_eq("pre_clr_corr", 32'(corr_cnt), 32'd1);
    in_code  = 8'hAB;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check_eq("clr_hs_valid", 32'(out_valid), 32'd1);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    check_eq("clr_hs_corr", 32'(corr_cnt), 32'd0);

    // Reset mid-stream drops in-flight words.
    in_code  = 8'hAC;
    in_valid = 1'b1;
    step();
    step();
    check_eq("mid_valid", 32'(out_valid), 32'd1);
    rst      = 1'b1;
    in_valid = 1'b0;
    step();
    rst = 1'b0;
    check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
    check_eq("mid_rst_ready", 32'(in_ready), 32'd1);
    step();
    check_eq("mid_rst_drop", 32'(out_valid), 32'd0);
    check_eq("mid_rst_uncorr", 32'(uncorr_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
